f1_start_ctrl: RTL

- Sequencer for the F1 start-light FSM (9-state, 0→8 lights on, wraps S8→S0 on its next enable).
- Generates that FSM's enable as single-cycle step pulses:
  - eight paced steps build the lights;
  - a pseudo-random hold follows;
  - a ninth step returns the FSM to S0 (lights out).
- Times the driver's reaction from lights-out and flags jump starts.
- Sits between the top-level button inputs and the light FSM.

---
 rtl/f1_start_ctrl_pkg.sv | 27 ++
 rtl/f1_start_ctrl_if.sv | 32 +++
 rtl/f1_start_ctrl_lfsr7.sv | 21 ++
 rtl/f1_start_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/f1_start_ctrl_pkg.sv
// f1_pkg: shared types and constants for the F1 start-light sequencer.
//   state_t    - sequencer FSM states
//   NUM_LIGHTS - number of build steps before the hold phase
//   LFSR_*     - width/taps of the 7-bit Fibonacci LFSR (x^7 + x^6 + 1)
//   lfsr_next  - one-step LFSR advance, shared by RTL users of the LFSR
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUILD,
    HOLD,
    RACE,
    ABORT
  } state_t;

  localparam int NUM_LIGHTS = 8;

  localparam int LFSR_W     = 7;
  localparam int LFSR_TAP_A = 6;
  localparam int LFSR_TAP_B = 5;

  // New bit enters at bit 0; taps at bits 6 and 5 give a maximal 127-state cycle.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/f1_start_ctrl_if.sv
// f1_start_ctrl_if: button-side and light-FSM-side signals of the start sequencer.
//   trigger     - start request (driver side -> sequencer)
//   react       - driver button, level (driver side -> sequencer)
//   step        - one-cycle enable pulse for the light FSM
//   busy        - sequencer not idle
//   lights_out  - one-cycle pulse with the final (lights-out) step
//   react_time  - last measured reaction time in cycles
//   react_valid - one-cycle pulse when react_time updates
//   jump_start  - sticky early-react flag
// master = stimulus/top-level side, slave = the sequencer.
interface f1_start_ctrl_if #(
  parameter int RT_W = 16
);
  logic            trigger;
  logic            react;
  logic            step;
  logic            busy;
  logic            lights_out;
  logic [RT_W-1:0] react_time;
  logic            react_valid;
  logic            jump_start;

  modport master (
    output trigger, react,
    input  step, busy, lights_out, react_time, react_valid, jump_start
  );

  modport slave (
    input  trigger, react,
    output step, busy, lights_out, react_time, react_valid, jump_start
  );
endinterface

// File: rtl/f1_start_ctrl_lfsr7.sv
// lfsr7: free-running 7-bit Fibonacci LFSR, x^7 + x^6 + 1.
//   clk  - clock
//   rst  - synchronous active-low reset, loads SEED
//   q    - current LFSR state, advances every cycle
// SEED must be non-zero or the register locks up at zero.
module lfsr7
  import f1_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 7'h01
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= SEED;
    else      q <= lfsr_next(q);
  end

endmodule

// File: rtl/f1_start_ctrl.sv
// f1_start_ctrl: sequencer driving the enable of a 9-state start-light FSM.
//   clk - clock
//   rst - synchronous active-low reset (light FSM is reset from the same net)
//   bus - f1_start_ctrl_if.slave: trigger/react in; step, busy, lights_out,
//         react_time, react_valid, jump_start out
// A run issues exactly nine step pulses: eight paced build steps, a random
// hold, then the lights-out step. An early react aborts the pacing and
// flushes the remaining steps back-to-back so the light FSM lands in S0.
// step, lights_out, react_valid are registered: a step decided at edge N is
// visible during the cycle after edge N.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int                TICK_CYCLES = 4,
  parameter int                MIN_HOLD    = 2,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 7'h01,
  parameter int                RT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  f1_start_ctrl_if.slave    bus
);

  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam int HOLD_W = $clog2(MIN_HOLD + 16);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_CYCLES - 1);
  localparam logic [3:0]        LAST_BUILD  = 4'(NUM_LIGHTS - 1);
  localparam logic [3:0]        STEPS_TOTAL = 4'(NUM_LIGHTS + 1);

  state_t            state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_n;
  logic [3:0]        step_cnt, step_cnt_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [RT_W-1:0]   rt_cnt, rt_n;
  logic [RT_W-1:0]   rtime_q, rtime_n;
  logic              step_q, step_n;
  logic              lo_q, lo_n;
  logic              rv_q, rv_n;
  logic              js_q, js_n;
  logic              tick_end;

  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr;

  lfsr7 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low nibble randomises the hold.
  assign unused_lfsr = ^lfsr_q[LFSR_W-1:4];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
      rt_cnt   <= '0;
      rtime_q  <= '0;
      step_q   <= 1'b0;
      lo_q     <= 1'b0;
      rv_q     <= 1'b0;
      js_q     <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      step_cnt <= step_cnt_n;
      hold_cnt <= hold_n;
      rt_cnt   <= rt_n;
      rtime_q  <= rtime_n;
      step_q   <= step_n;
      lo_q     <= lo_n;
      rv_q     <= rv_n;
      js_q     <= js_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    step_cnt_n = step_cnt;
    hold_n     = hold_cnt;
    rt_n       = rt_cnt;
    rtime_n    = rtime_q;
    step_n     = 1'b0;
    lo_n       = 1'b0;
    rv_n       = 1'b0;
    js_n       = js_q;
    tick_end   = (tick_cnt == TICK_LAST);

    case (state)
      IDLE: begin
        if (bus.trigger) begin
          state_n    = BUILD;
          tick_n     = '0;
          step_cnt_n = '0;
          js_n       = 1'b0;
        end
      end

      BUILD: begin
        // react outranks a coinciding tick; ABORT issues the missed step
        if (bus.react) begin
          state_n = ABORT;
          js_n    = 1'b1;
        end else if (tick_end) begin
          tick_n     = '0;
          step_n     = 1'b1;
          step_cnt_n = step_cnt + 4'd1;
          if (step_cnt == LAST_BUILD) begin
            state_n = HOLD;
            hold_n  = HOLD_W'(MIN_HOLD) + HOLD_W'(lfsr_q[3:0]);
          end
        end else begin
          tick_n = tick_cnt + 1'b1;
        end
      end

      HOLD: begin
        if (bus.react) begin
          state_n = ABORT;
          js_n    = 1'b1;
        end else if (tick_end) begin
          tick_n = '0;
          // <=1 also covers a zero load, which fires on the first tick
          if (hold_cnt <= HOLD_W'(1)) begin
            step_n     = 1'b1;
            lo_n       = 1'b1;
            step_cnt_n = STEPS_TOTAL;
            state_n    = RACE;
            rt_n       = '0;
          end else begin
            hold_n = hold_cnt - 1'b1;
          end
        end else begin
          tick_n = tick_cnt + 1'b1;
        end
      end

      RACE: begin
        if (bus.react) begin
          rtime_n = rt_cnt;
          rv_n    = 1'b1;
          state_n = IDLE;
        end else if (rt_cnt != '1) begin
          rt_n = rt_cnt + 1'b1;
        end
      end

      ABORT: begin
        // flush remaining steps one per cycle so the light FSM wraps to S0
        if (step_cnt < STEPS_TOTAL) begin
          step_n     = 1'b1;
          step_cnt_n = step_cnt + 4'd1;
          if (step_cnt == STEPS_TOTAL - 4'd1) state_n = IDLE;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.step        = step_q;
  assign bus.busy        = (state != IDLE);
  assign bus.lights_out  = lo_q;
  assign bus.react_time  = rtime_q;
  assign bus.react_valid = rv_q;
  assign bus.jump_start  = js_q;

endmodule
